scale_up: RTL and testbench

- 2x nearest-neighbour upscaler, the inverse of the 128x128 to 64x64 scale-down path.
- Pulls a 64x64 8-bit image from a pixel source through the `ask`/`in` handshake.
- Emits a 128x128 image through the `display`/`out` stream.
- Each source pixel is replicated horizontally (2 columns) and vertically (2 rows) using a one-line buffer.

---
 rtl/scale_pkg.sv | 23 ++
 rtl/scale_line_buf.sv | 35 +++
 rtl/scale_up.sv | 155 +++++++++++++++
 tb/tb_scale_up.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// scale_pkg: shared constants, state encoding and width helper for the
// 2x nearest-neighbour upscaler (scale_up) and its line buffer.
package scale_pkg;

    localparam int IMG_IN_W = 64;   // source image width in pixels
    localparam int IMG_IN_H = 64;   // source image height in rows
    localparam int PIX_W    = 8;    // pixel width in bits

    // Counter/address width for a range of n values, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Line-buffer address width for the default source width.
    localparam int IMG_COL_AW = cnt_w(IMG_IN_W);

    typedef enum logic [1:0] {
        FETCH,
        REPLAY,
        DONE
    } state_t;

endpackage

// File: rtl/scale_line_buf.sv
// scale_line_buf: one source line of pixels.
// One synchronous write port and one asynchronous read port, so a write and
// a read can both happen in the same cycle.
//   clk   : clock
//   we    : write enable
//   waddr : write address (source column)
//   wdata : pixel to store
//   raddr : read address (source column)
//   rdata : pixel at raddr (combinational)
module scale_line_buf
    import scale_pkg::*;
#(
    parameter int DEPTH = IMG_IN_W,
    parameter int DW    = PIX_W,
    parameter int AW    = IMG_COL_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/scale_up.sv
// scale_up: 2x nearest-neighbour upscaler. Pulls an IN_W x IN_H image in
// raster order through ask/in and emits a 2*IN_W x 2*IN_H image on out.
// Each output row pair is a FETCH pass (every source pixel shown twice as it
// arrives, and stored) followed by a REPLAY pass from the line buffer.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low
//   in      : source pixel, valid the cycle after ask
//   out     : output pixel, valid while display=1
//   display : out holds an output pixel this cycle
//   ask     : request for the next source pixel
//   done    : whole frame emitted (sticky until reset)
module scale_up
    import scale_pkg::*;
#(
    parameter int IN_W = IMG_IN_W,
    parameter int IN_H = IMG_IN_H,
    parameter int DW   = PIX_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in,
    output logic [DW-1:0] out,
    output logic          display,
    output logic          ask,
    output logic          done
);

    localparam int AW    = cnt_w(IN_W);
    localparam int COL_W = AW + 1;          // 2*IN_W output slots per pass
    localparam int ROW_W = cnt_w(IN_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(2 * IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

    state_t           state, state_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic             ask_nxt;

    // Control stage delayed by two cycles so that it lines up with the
    // pixel that arrives one cycle after the registered ask.
    logic             vld_p1, fetch_p1, fin_p1;
    logic [COL_W-1:0] col_p1;
    logic             vld_p2, fetch_p2, fin_p2;
    logic [COL_W-1:0] col_p2;

    logic             lb_we;
    logic [DW-1:0]    lb_rdata;

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        ask_nxt   = 1'b0;
        case (state)
            FETCH: begin
                ask_nxt = ~col[0];
                col_nxt = (col == COL_LAST) ? '0 : col + 1'b1;
                if (col == COL_LAST) begin
                    state_nxt = REPLAY;
                end
            end
            REPLAY: begin
                col_nxt = (col == COL_LAST) ? '0 : col + 1'b1;
                if (col == COL_LAST) begin
                    if (row == ROW_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        row_nxt   = row + 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            col   <= '0;
            row   <= '0;
            ask   <= 1'b0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            ask   <= ask_nxt;
        end
    end

    // ---- stage p1: control of the current slot ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            fetch_p1 <= 1'b0;
            fin_p1   <= 1'b0;
            col_p1   <= '0;
        end else begin
            vld_p1   <= (state != DONE);
            fetch_p1 <= (state == FETCH);
            fin_p1   <= (state == DONE);
            col_p1   <= col;
        end
    end

    // ---- stage p2: source pixel for even FETCH slots is on `in` now ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2   <= 1'b0;
            fetch_p2 <= 1'b0;
            fin_p2   <= 1'b0;
            col_p2   <= '0;
        end else begin
            vld_p2   <= vld_p1;
            fetch_p2 <= fetch_p1;
            fin_p2   <= fin_p1;
            col_p2   <= col_p1;
        end
    end

    assign lb_we = vld_p2 & fetch_p2 & ~col_p2[0];

    scale_line_buf #(
        .DEPTH (IN_W),
        .DW    (DW),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (col_p2[COL_W-1:1]),
        .wdata (in),
        .raddr (col_p2[COL_W-1:1]),
        .rdata (lb_rdata)
    );

    // ---- output stage: odd FETCH slots repeat the pixel already on out ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out     <= '0;
            display <= 1'b0;
            done    <= 1'b0;
        end else begin
            display <= vld_p2;
            done    <= fin_p2;
            if (vld_p2) begin
                if (!fetch_p2) begin
                    out <= lb_rdata;
                end else if (!col_p2[0]) begin
                    out <= in;
                end
            end
        end
    end

endmodule

// File: tb/tb_scale_up.sv
module tb_scale_up;
    import scale_pkg::*;

    localparam int W    = IMG_IN_W;
    localparam int H    = IMG_IN_H;
    localparam int OW   = 2 * W;
    localparam int OH   = 2 * H;
    localparam int NPIX = OW * OH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in = 8'h00;
    logic [7:0] out;
    logic       display, ask, done;

    scale_up dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .out     (out),
        .display (display),
        .ask     (ask),
        .done    (done)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         ask_cnt = 0;
    int         disp_cnt = 0;
    logic [7:0] src [H][W];
    logic [7:0] cap [NPIX];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: every output pixel (r,c) is source pixel (r/2,c/2), raster order.
    task automatic load_expected();
        exp_q.delete();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                exp_q.push_back(src[r / 2][c / 2]);
    endtask

    // Pixel source: answers each ask with the next raster pixel one cycle later,
    // random garbage otherwise.
    initial begin
        int   idx;
        logic a;
        idx = 0;
        forever begin
            @(negedge clk);
            a = ask && reset;
            if (!reset) idx = 0;
            @(posedge clk);
            #1;
            if (a && idx < W * H) begin
                in = src[idx / W][idx % W];
                idx++;
            end else begin
                in = 8'($urandom);
            end
        end
    end

    // Monitor: frame-level timing from cycle number, pixels from the scoreboard.
    initial begin
        logic       e_ask, e_disp, e_done;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("reset_outputs", 32'({ask, display, done, out}), 32'd0);
                ask_cnt  = 0;
                disp_cnt = 0;
            end else begin
                e_ask  = (cyc >= 1) && (cyc <= NPIX) &&
                         (((cyc - 1) % (2 * OW)) < OW) && (((cyc - 1) % 2) == 0);
                e_disp = (cyc >= 3) && (cyc <= NPIX + 2);
                e_done = (cyc >= NPIX + 3);
                check("ask_display_done", 32'({ask, display, done}), 32'({e_ask, e_disp, e_done}));
                if (ask) ask_cnt++;
                if (display) begin
                    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("pixel", 32'(out), 32'(e));
                    end
                    if (disp_cnt < NPIX) cap[disp_cnt] = out;
                    disp_cnt++;
                end
            end
        end
    end

    task automatic first_checks();
        int k;
        k = 0;
        @(negedge clk);
        while (!ask && k < 20) begin @(negedge clk); k++; end
        check("first_ask_cycle", 32'(cyc), 32'd1);
        k = 0;
        while (!display && k < 20) begin @(negedge clk); k++; end
        check("first_display_cycle", 32'(cyc), 32'd3);
        check("first_pixel", 32'(out), 32'(src[0][0]));
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < NPIX + 100) begin @(negedge clk); k++; end
        check("done_cycle", 32'(cyc), 32'(NPIX + 3));
        check("ask_total", 32'(ask_cnt), 32'(W * H));
        check("display_total", 32'(disp_cnt), 32'(NPIX));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic enter_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic leave_reset(input int n);
        repeat (n) @(posedge clk);
        #3 reset = 1'b1;
    endtask

    initial begin
        int nm;
        #1 reset = 1'b0;

        // Frame 1: row 0 reads 10,11,...,4F.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                src[y][x] = 8'(16 + y * 4 + x);
        load_expected();
        leave_reset(5);
        first_checks();
        wait_done();
        repeat (1000) @(negedge clk);
        check("done_sticky", 32'(done), 32'd1);

        // Frame 2: random image, aborted in cycle 1000.
        enter_reset();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                src[y][x] = 8'($urandom);
        load_expected();
        leave_reset(3);
        first_checks();
        for (int k = 0; k < 2000 && cyc != 1000; k++) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1 check("async_clear", 32'({ask, display, done, out}), 32'd0);
        exp_q.delete();

        // Frame 3: (y*4+x) mod 256 after the abort.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                src[y][x] = 8'(y * 4 + x);
        load_expected();
        leave_reset(3);
        first_checks();
        wait_done();

        // Frame 4: all FF except last source row 00.
        enter_reset();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                src[y][x] = (y == H - 1) ? 8'h00 : 8'hFF;
        load_expected();
        leave_reset(3);
        first_checks();
        wait_done();
        for (int r = OH - 3; r < OH; r++) begin
            nm = 0;
            for (int c = 0; c < OW; c++)
                if (cap[r * OW + c] === ((r >= OH - 2) ? 8'h00 : 8'hFF)) nm++;
            check($sformatf("boundary_row%0d", r), 32'(nm), 32'(OW));
        end

        // Frame 5: random image, full frame.
        enter_reset();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                src[y][x] = 8'($urandom);
        load_expected();
        leave_reset(3);
        first_checks();
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
